clock_adjust: RTL

CLOCK_ADJUST -- requirements
Module: clock_adjust

---
 rtl/clock_adjust.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_adjust.sv
// Preset controller for a BCD time-of-day timer: debounced up/down buttons step H/M/S.
// Optional auto-repeat on held buttons is built when CLOCK_ADJUST_AUTO_REPEAT_EN is defined.
module clock_adjust #(
  parameter int unsigned DEB_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned RPT_DELAY      = 5000,
  parameter int unsigned RPT_PERIOD     = 2000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       HU,
  input  logic       HD,
  input  logic       MU,
  input  logic       MD,
  input  logic       SU,
  input  logic       SD,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  output logic       PE,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S
);

  localparam int unsigned NB     = 6;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ADJUST = 1'b1;

  logic [NB-1:0] w_btn;
  logic [NB-1:0] r_sync1, r_sync2, r_deb, r_deb_q;
  logic [NB-1:0] w_press, w_rpt, w_step;

  // Bit order: 0=HU 1=HD 2=MU 3=MD 4=SU 5=SD (lowest index has priority)
  assign w_btn   = {SD, SU, MD, MU, HD, HU};
  assign w_press = r_deb & ~r_deb_q;
  assign w_step  = w_press | w_rpt;

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_q <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_deb
    logic [DEB_W-1:0] r_deb_cnt;
    // Accept the new level after DEB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        r_deb[g]  <= 1'b0;
        r_deb_cnt <= '0;
      end else if (r_sync2[g] != r_deb[g]) begin
        if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb[g]  <= r_sync2[g];
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

`ifdef CLOCK_ADJUST_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  for (genvar g = 0; g < NB; g++) begin : g_rpt
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    // Counting starts on the press cycle; first repeat after RPT_DELAY, then every RPT_PERIOD
    assign w_rpt[g] = r_deb[g] && r_deb_q[g] &&
                      (r_rpt_first ? (r_rpt_cnt == RPT_W'(RPT_DELAY - 1))
                                   : (r_rpt_cnt == RPT_W'(RPT_PERIOD - 1)));
    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end else if (!r_deb[g]) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b1;
      end else if (w_rpt[g]) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
  assign w_rpt        = '0;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)         return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)        return vmax;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [0:0]        r_state, w_state_nxt;
  logic              r_pe, w_pe_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [7:0]        r_d_h, r_d_m, r_d_s;
  logic [7:0]        w_d_h_nxt, w_d_m_nxt, w_d_s_nxt;
  logic [7:0]        w_base_h, w_base_m, w_base_s;
  logic              w_any;
  logic [2:0]        w_idx;

  always_comb begin
    w_any = 1'b1;
    w_idx = 3'd0;
    casez (w_step)
      6'b?????1: w_idx = 3'd0;
      6'b????10: w_idx = 3'd1;
      6'b???100: w_idx = 3'd2;
      6'b??1000: w_idx = 3'd3;
      6'b?10000: w_idx = 3'd4;
      6'b100000: w_idx = 3'd5;
      default:   w_any = 1'b0;
    endcase
  end

  // IDLE steps from the captured timer value, ADJUST from the current preset
  always_comb begin
    w_state_nxt = r_state;
    w_pe_nxt    = r_pe;
    w_idle_nxt  = r_idle_cnt;
    w_base_h    = (r_state == ST_IDLE) ? Q_H : r_d_h;
    w_base_m    = (r_state == ST_IDLE) ? Q_M : r_d_m;
    w_base_s    = (r_state == ST_IDLE) ? Q_S : r_d_s;
    w_d_h_nxt   = r_d_h;
    w_d_m_nxt   = r_d_m;
    w_d_s_nxt   = r_d_s;
    if (w_any) begin
      w_d_h_nxt = w_base_h;
      w_d_m_nxt = w_base_m;
      w_d_s_nxt = w_base_s;
      case (w_idx)
        3'd0:    w_d_h_nxt = bcd_inc(w_base_h, 8'h23);
        3'd1:    w_d_h_nxt = bcd_dec(w_base_h, 8'h23);
        3'd2:    w_d_m_nxt = bcd_inc(w_base_m, 8'h59);
        3'd3:    w_d_m_nxt = bcd_dec(w_base_m, 8'h59);
        3'd4:    w_d_s_nxt = bcd_inc(w_base_s, 8'h59);
        default: w_d_s_nxt = bcd_dec(w_base_s, 8'h59);
      endcase
    end
    case (r_state)
      ST_IDLE: begin
        w_pe_nxt   = 1'b0;
        w_idle_nxt = '0;
        if (w_any) begin
          w_state_nxt = ST_ADJUST;
          w_pe_nxt    = 1'b1;
        end
      end
      default: begin
        w_pe_nxt = 1'b1;
        if (w_any) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_pe_nxt    = 1'b0;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_state    <= ST_IDLE;
      r_pe       <= 1'b0;
      r_idle_cnt <= '0;
      r_d_h      <= 8'h00;
      r_d_m      <= 8'h00;
      r_d_s      <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_pe       <= w_pe_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_d_h      <= w_d_h_nxt;
      r_d_m      <= w_d_m_nxt;
      r_d_s      <= w_d_s_nxt;
    end
  end

  assign PE  = r_pe;
  assign D_H = r_d_h;
  assign D_M = r_d_m;
  assign D_S = r_d_s;

endmodule
